// File: rtl/start_referee.sv
// Round sequencer/arbiter for the tug-of-war game: random start delay, GO, first-press and foul decisions.
// Optional GO-phase timeout is built only when START_TIMEOUT_EN is defined.
module start_referee #(
  parameter int DELAY_BITS    = 4,
  parameter int MIN_DELAY     = 2,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  input  logic rin,
  input  logic btn_l,
  input  logic btn_r,
  output logic busy,
  output logic go,
  output logic win_l,
  output logic win_r,
  output logic foul_l,
  output logic foul_r,
  output logic timeout,
  output logic done
);

  localparam int CNT_W = DELAY_BITS + 1 + $clog2(MIN_DELAY + 1);
  localparam int BC_W  = 4;

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_WAIT, S_GO, S_RESULT} state_t;

  state_t                r_state, w_state;
  logic [DELAY_BITS-1:0] r_delay, w_delay, w_delay_sh;
  logic [BC_W-1:0]       r_bitcnt, w_bitcnt;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic                  r_prio, w_prio;
  logic                  r_win_l, w_win_l, r_win_r, w_win_r;
  logic                  r_foul_l, w_foul_l, r_foul_r, w_foul_r;
  logic                  r_timeout, w_timeout;
  logic                  r_busy, r_go, r_done;
  logic                  w_tmo_hit;

`ifdef START_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TC_W-1:0] r_tcnt, w_tcnt;

  // Tick counter lives only in GO; it restarts from zero on every GO entry.
  always_comb begin
    w_tcnt = '0;
    if (r_state == S_GO)
      w_tcnt = tick ? r_tcnt + TC_W'(1) : r_tcnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tcnt <= '0;
    else     r_tcnt <= w_tcnt;
  end

  assign w_tmo_hit = tick && (r_tcnt == TC_W'(TIMEOUT_TICKS - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // New bits enter at the MSB so the first bit received ends up as the LSB.
  assign w_delay_sh = (r_delay >> 1) |
                      ({DELAY_BITS{rin}} & (DELAY_BITS'(1) << (DELAY_BITS - 1)));

  always_comb begin
    w_state   = r_state;
    w_delay   = r_delay;
    w_bitcnt  = r_bitcnt;
    w_cnt     = r_cnt;
    w_prio    = r_prio;
    w_win_l   = r_win_l;
    w_win_r   = r_win_r;
    w_foul_l  = r_foul_l;
    w_foul_r  = r_foul_r;
    w_timeout = r_timeout;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state = S_SEED;
      end
      S_SEED: begin
        w_delay  = w_delay_sh;
        w_bitcnt = r_bitcnt + BC_W'(1);
        if (r_bitcnt == BC_W'(DELAY_BITS - 1)) begin
          w_bitcnt = '0;
          w_cnt    = CNT_W'(w_delay_sh) + CNT_W'(MIN_DELAY);
          w_state  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A press before GO beats a tick arriving on the same clock.
        if (btn_l || btn_r) begin
          w_foul_l = btn_l;
          w_foul_r = btn_r;
          w_win_l  = btn_r && !btn_l;
          w_win_r  = btn_l && !btn_r;
          w_state  = S_RESULT;
        end else if (tick) begin
          if (r_cnt == CNT_W'(1)) w_state = S_GO;
          else                    w_cnt   = r_cnt - CNT_W'(1);
        end
      end
      S_GO: begin
        if (btn_l && btn_r) begin
          w_win_l = !r_prio;
          w_win_r = r_prio;
          w_prio  = !r_prio;
          w_state = S_RESULT;
        end else if (btn_l) begin
          w_win_l = 1'b1;
          w_state = S_RESULT;
        end else if (btn_r) begin
          w_win_r = 1'b1;
          w_state = S_RESULT;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_state   = S_RESULT;
        end
      end
      S_RESULT: begin
        if (start) begin
          w_win_l   = 1'b0;
          w_win_r   = 1'b0;
          w_foul_l  = 1'b0;
          w_foul_r  = 1'b0;
          w_timeout = 1'b0;
          w_state   = S_SEED;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_delay   <= '0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_prio    <= 1'b0;
      r_win_l   <= 1'b0;
      r_win_r   <= 1'b0;
      r_foul_l  <= 1'b0;
      r_foul_r  <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_delay   <= w_delay;
      r_bitcnt  <= w_bitcnt;
      r_cnt     <= w_cnt;
      r_prio    <= w_prio;
      r_win_l   <= w_win_l;
      r_win_r   <= w_win_r;
      r_foul_l  <= w_foul_l;
      r_foul_r  <= w_foul_r;
      r_timeout <= w_timeout;
      r_busy    <= (w_state == S_SEED) || (w_state == S_WAIT) || (w_state == S_GO);
      r_go      <= (w_state == S_GO);
      r_done    <= (w_state == S_RESULT);
    end
  end

  assign busy    = r_busy;
  assign go      = r_go;
  assign win_l   = r_win_l;
  assign win_r   = r_win_r;
  assign foul_l  = r_foul_l;
  assign foul_r  = r_foul_r;
  assign timeout = r_timeout;
  assign done    = r_done;

endmodule
